// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and geometry for the I/D-cache to burst-memory arbiter.
package mem_arb_pkg;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int ADDR_W = 32;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} arb_state_t;
    typedef enum logic {SRC_I, SRC_D} arb_src_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction
endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-side and memory-side buses of the arbiter; slave is the arbiter's view.
interface cache_mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [BEAT_W-1:0] mem_wdata;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata, mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter_buf.sv
// Line buffer plus beat counter: assembles read beats and serves write beats.
module line_burst_buffer
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_line,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_capture_beat,
    input  logic [BEAT_W-1:0] i_beat_in,
    input  logic              i_advance,
    input  logic              i_clr,
    output logic [BEAT_W-1:0] o_beat_out,
    output logic              o_last_beat,
    output logic [LINE_W-1:0] o_line
);
    logic [LINE_W-1:0] r_line;
    logic [CNT_W-1:0]  r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_load_line)
                r_line <= i_line;
            else if (i_capture_beat)
                r_line[int'(r_cnt) * BEAT_W +: BEAT_W] <= i_beat_in;
            if (i_clr)
                r_cnt <= '0;
            else if (i_advance)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_beat_out  = r_line[int'(r_cnt) * BEAT_W +: BEAT_W];
    assign o_last_beat = (r_cnt == CNT_W'(BEATS - 1));
    assign o_line      = r_line;
endmodule

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter between I/D-cache line misses and one 4-beat burst memory port.
module cache_mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cache_mem_arbiter_if.slave bus
);
    arb_state_t        r_state;
    arb_src_t          r_last_grant;
    arb_src_t          r_grant;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_i_resp;
    logic              r_d_resp;
    logic [ADDR_W-1:0] r_mem_address;

    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_grant;
    arb_src_t          w_sel;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_capture;
    logic              w_advance;
    logic              w_last_beat;
    logic              w_burst_end;
    logic [BEAT_W-1:0] w_beat_out;
    logic [LINE_W-1:0] w_line;

    assign w_i_pend = bus.i_read;
    assign w_d_pend = bus.d_read | bus.d_write;
    assign w_grant  = (r_state == IDLE) && (w_i_pend || w_d_pend);

    // On contention the side that did not win last time goes first.
    always_comb begin
        w_sel = SRC_I;
        if (w_i_pend && w_d_pend)
            w_sel = (r_last_grant == SRC_I) ? SRC_D : SRC_I;
        else if (w_d_pend)
            w_sel = SRC_D;
    end

    assign w_sel_wr    = (w_sel == SRC_D) && bus.d_write;
    assign w_sel_addr  = (w_sel == SRC_D) ? bus.d_address : bus.i_address;
    assign w_capture   = (r_state == RD_BURST) && bus.mem_resp;
    assign w_advance   = ((r_state == RD_BURST) || (r_state == WR_BURST)) && bus.mem_resp;
    assign w_burst_end = w_advance && w_last_beat;

    line_burst_buffer u_buf (
        .clk            (clk),
        .rst            (rst),
        .i_load_line    (w_grant && w_sel_wr),
        .i_line         (bus.d_wdata),
        .i_capture_beat (w_capture),
        .i_beat_in      (bus.mem_rdata),
        .i_advance      (w_advance),
        .i_clr          (r_state == DONE),
        .o_beat_out     (w_beat_out),
        .o_last_beat    (w_last_beat),
        .o_line         (w_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= SRC_I;
            r_grant       <= SRC_I;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_i_resp      <= 1'b0;
            r_d_resp      <= 1'b0;
            r_mem_address <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_grant       <= w_sel;
                        r_last_grant  <= w_sel;
                        r_mem_address <= line_align(w_sel_addr);
                        r_mem_write   <= w_sel_wr;
                        r_mem_read    <= !w_sel_wr;
                        r_state       <= w_sel_wr ? WR_BURST : RD_BURST;
                    end
                end
                RD_BURST, WR_BURST: begin
                    // resp is raised on the last beat so it is visible exactly during DONE
                    if (w_burst_end) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_i_resp    <= (r_grant == SRC_I);
                        r_d_resp    <= (r_grant == SRC_D);
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i_rdata     = w_line;
    assign bus.d_rdata     = w_line;
    assign bus.i_resp      = r_i_resp;
    assign bus.d_resp      = r_d_resp;
    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_wdata   = w_beat_out;
endmodule
